// File: rtl/nf2_reg_target_pkg.sv
// Shared constants, FSM state type and address-map helpers for nf2_reg_target.
package nf2_reg_target_pkg;

  localparam int          DATA_WIDTH    = 32;
  localparam logic [31:0] UNMAPPED_DATA = 32'hDEADBEEF;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } state_t;

  typedef enum logic [1:0] {
    REGION_CNTR,
    REGION_SW,
    REGION_HW,
    REGION_NONE
  } region_t;

  function automatic int unsigned cntrBase();
    return 0;
  endfunction

  function automatic int unsigned swBase(input int unsigned numCntrs);
    return cntrBase() + numCntrs;
  endfunction

  function automatic int unsigned hwBase(input int unsigned numCntrs, input int unsigned numSw);
    return swBase(numCntrs) + numSw;
  endfunction

  // Regions are laid out back to back: counters, then SW regs, then HW regs.
  function automatic region_t decodeRegion(input logic [31:0] addr, input int unsigned numCntrs,
                                           input int unsigned numSw, input int unsigned numHw);
    if (addr < swBase(numCntrs))                           return REGION_CNTR;
    else if (addr < hwBase(numCntrs, numSw))               return REGION_SW;
    else if (addr < hwBase(numCntrs, numSw) + numHw)       return REGION_HW;
    else                                                   return REGION_NONE;
  endfunction

endpackage

// File: rtl/nf2_reg_target_if.sv
// Request/acknowledge register bus between the group decoder (master) and a block target (slave).
interface nf2_reg_target_if #(
  parameter int REG_ADDR_WIDTH = 22
);

  logic                      reg_req;
  logic                      reg_rd_wr_L;
  logic [REG_ADDR_WIDTH-1:0] reg_addr;
  logic [31:0]               reg_wr_data;
  logic                      reg_ack;
  logic [31:0]               reg_rd_data;

  modport master (
    output reg_req,
    output reg_rd_wr_L,
    output reg_addr,
    output reg_wr_data,
    input  reg_ack,
    input  reg_rd_data
  );

  modport slave (
    input  reg_req,
    input  reg_rd_wr_L,
    input  reg_addr,
    input  reg_wr_data,
    output reg_ack,
    output reg_rd_data
  );

endinterface

// File: rtl/nf2_reg_target_cntr.sv
// Single saturating counter with a software load port.
// Optional NF2_REG_TARGET_CLR_ON_READ_EN adds a clear port that keeps the same-cycle increment.
module nf2_reg_target_cntr #(
  parameter int CNTR_WIDTH = 32,
  parameter int INC_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INC_WIDTH-1:0]  i_inc,
  input  logic                  i_load,
  input  logic [CNTR_WIDTH-1:0] i_load_data,
`ifdef NF2_REG_TARGET_CLR_ON_READ_EN
  input  logic                  i_clr,
`endif
  output logic [CNTR_WIDTH-1:0] o_value
);

  // One spare bit above the wider operand so the sum can never wrap before the clamp.
  localparam int SUM_WIDTH = ((CNTR_WIDTH > INC_WIDTH) ? CNTR_WIDTH : INC_WIDTH) + 1;
  localparam logic [SUM_WIDTH-1:0] MAX_VAL = {{(SUM_WIDTH-CNTR_WIDTH){1'b0}}, {CNTR_WIDTH{1'b1}}};

  logic [CNTR_WIDTH-1:0] r_cnt;
  logic [SUM_WIDTH-1:0]  w_sum;
  logic [CNTR_WIDTH-1:0] w_satSum;
  logic [CNTR_WIDTH-1:0] w_next;

  assign w_sum    = SUM_WIDTH'(r_cnt) + SUM_WIDTH'(i_inc);
  assign w_satSum = (w_sum > MAX_VAL) ? {CNTR_WIDTH{1'b1}} : w_sum[CNTR_WIDTH-1:0];

`ifdef NF2_REG_TARGET_CLR_ON_READ_EN
  logic [SUM_WIDTH-1:0]  w_incExt;
  logic [CNTR_WIDTH-1:0] w_incSat;

  assign w_incExt = SUM_WIDTH'(i_inc);
  assign w_incSat = (w_incExt > MAX_VAL) ? {CNTR_WIDTH{1'b1}} : w_incExt[CNTR_WIDTH-1:0];
`endif

  always_comb begin
    w_next = w_satSum;
    if (i_load) begin
      w_next = i_load_data;
    end
`ifdef NF2_REG_TARGET_CLR_ON_READ_EN
    else if (i_clr) begin
      w_next = w_incSat;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

  assign o_value = r_cnt;

endmodule

// File: rtl/nf2_reg_target.sv
// Generic register target: counters, RW software registers and RO hardware registers on the req/ack bus.
// Define NF2_REG_TARGET_CLR_ON_READ_EN to make counter reads clear the counter.
module nf2_reg_target
  import nf2_reg_target_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 22,
  parameter int NUM_CNTRS      = 4,
  parameter int CNTR_WIDTH     = 32,
  parameter int INC_WIDTH      = 4,
  parameter int NUM_SW_REGS    = 4,
  parameter int NUM_HW_REGS    = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  nf2_reg_target_if.slave                 bus,
  input  logic [NUM_CNTRS*INC_WIDTH-1:0]  cntr_inc,
  output logic [NUM_SW_REGS*32-1:0]       sw_regs,
  input  logic [NUM_HW_REGS*32-1:0]       hw_regs
);

  localparam int unsigned CNTR_BASE = cntrBase();
  localparam int unsigned SW_BASE   = swBase(NUM_CNTRS);
  localparam int unsigned HW_BASE   = hwBase(NUM_CNTRS, NUM_SW_REGS);

  state_t                  r_state;
  state_t                  w_nextState;
  logic                    r_reqD1;
  logic                    w_newReq;
  logic                    w_access;
  logic                    w_isRead;
  logic                    r_ack;
  logic                    w_ackNext;
  logic [DATA_WIDTH-1:0]   r_rdData;
  logic [DATA_WIDTH-1:0]   w_rdDataNext;
  logic [DATA_WIDTH-1:0]   w_readValue;
  region_t                 w_region;
  logic [NUM_CNTRS-1:0]    w_cntrLoad;
  logic [CNTR_WIDTH-1:0]   w_cntrVal [NUM_CNTRS];
  logic [NUM_SW_REGS-1:0]  w_swWrite;
  logic [DATA_WIDTH-1:0]   r_swRegs  [NUM_SW_REGS];
`ifdef NF2_REG_TARGET_CLR_ON_READ_EN
  logic [NUM_CNTRS-1:0]    w_cntrClr;
`endif

  // A request is serviced only on its rising edge, so a long-held req is performed once.
  assign w_newReq = bus.reg_req & ~r_reqD1;
  assign w_access = (r_state == ST_IDLE) & w_newReq;
  assign w_isRead = bus.reg_rd_wr_L;
  assign w_region = decodeRegion(32'(bus.reg_addr), NUM_CNTRS, NUM_SW_REGS, NUM_HW_REGS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_reqD1  <= 1'b0;
      r_ack    <= 1'b0;
      r_rdData <= '0;
    end else begin
      r_state  <= w_nextState;
      r_reqD1  <= bus.reg_req;
      r_ack    <= w_ackNext;
      r_rdData <= w_rdDataNext;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_ackNext    = r_ack;
    w_rdDataNext = r_rdData;
    case (r_state)
      ST_IDLE: begin
        w_ackNext    = 1'b0;
        w_rdDataNext = '0;
        if (w_access) begin
          w_nextState  = ST_ACK;
          w_ackNext    = 1'b1;
          w_rdDataNext = w_isRead ? w_readValue : '0;
        end
      end
      ST_ACK: begin
        if (!bus.reg_req) begin
          w_nextState  = ST_IDLE;
          w_ackNext    = 1'b0;
          w_rdDataNext = '0;
        end
      end
      default: begin
        w_nextState  = ST_IDLE;
        w_ackNext    = 1'b0;
        w_rdDataNext = '0;
      end
    endcase
  end

  // Read mux and per-register strobes; strobes only fire in the request-detect cycle.
  always_comb begin
    w_readValue = UNMAPPED_DATA;
    w_cntrLoad  = '0;
    w_swWrite   = '0;
`ifdef NF2_REG_TARGET_CLR_ON_READ_EN
    w_cntrClr   = '0;
`endif
    case (w_region)
      REGION_CNTR: begin
        for (int i = 0; i < NUM_CNTRS; i++) begin
          if (bus.reg_addr == REG_ADDR_WIDTH'(CNTR_BASE + i)) begin
            w_readValue   = DATA_WIDTH'(w_cntrVal[i]);
            w_cntrLoad[i] = w_access & ~w_isRead;
`ifdef NF2_REG_TARGET_CLR_ON_READ_EN
            w_cntrClr[i]  = w_access & w_isRead;
`endif
          end
        end
      end
      REGION_SW: begin
        for (int j = 0; j < NUM_SW_REGS; j++) begin
          if (bus.reg_addr == REG_ADDR_WIDTH'(SW_BASE + j)) begin
            w_readValue  = r_swRegs[j];
            w_swWrite[j] = w_access & ~w_isRead;
          end
        end
      end
      REGION_HW: begin
        for (int k = 0; k < NUM_HW_REGS; k++) begin
          if (bus.reg_addr == REG_ADDR_WIDTH'(HW_BASE + k)) begin
            w_readValue = hw_regs[k*32 +: 32];
          end
        end
      end
      default: begin
        w_readValue = UNMAPPED_DATA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_SW_REGS; j++) begin
        r_swRegs[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_SW_REGS; j++) begin
        if (w_swWrite[j]) begin
          r_swRegs[j] <= bus.reg_wr_data;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CNTRS; gi++) begin : g_cntr
    nf2_reg_target_cntr #(
      .CNTR_WIDTH (CNTR_WIDTH),
      .INC_WIDTH  (INC_WIDTH)
    ) u_cntr (
      .clk         (clk),
      .reset       (reset),
      .i_inc       (cntr_inc[gi*INC_WIDTH +: INC_WIDTH]),
      .i_load      (w_cntrLoad[gi]),
      .i_load_data (bus.reg_wr_data[CNTR_WIDTH-1:0]),
`ifdef NF2_REG_TARGET_CLR_ON_READ_EN
      .i_clr       (w_cntrClr[gi]),
`endif
      .o_value     (w_cntrVal[gi])
    );
  end

  for (genvar gj = 0; gj < NUM_SW_REGS; gj++) begin : g_swOut
    assign sw_regs[gj*32 +: 32] = r_swRegs[gj];
  end

  assign bus.reg_ack     = r_ack;
  assign bus.reg_rd_data = r_rdData;

endmodule
